param_iter_counter: RTL and testbench

- Parametrised iteration down-counter for the sequential divider datapath; successor to the fixed 3-bit divider down-counter.
- Loads an iteration count and decrements once per divider step.
- Flags the last iteration and pulses done on terminal count.
- Supports optional auto-reload so the divider can run back-to-back divisions without control-FSM reload overhead.

---
 rtl/param_iter_counter.sv | 74 +++++++
 tb/tb_param_iter_counter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_iter_counter.sv
// Parametrised iteration down-counter for the sequential divider.
// Ports: i_clk, clr_n, ld_cnt/ld_val load, dec_en step, counter/busy/last/zero/done status.
module param_iter_counter #(
  parameter int unsigned CNT_W       = 3,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             i_clk,
  input  logic             clr_n,
  input  logic             ld_cnt,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] counter,
  output logic             busy,
  output logic             last,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_reload;
  logic             r_done;

  logic             w_ld_nz;
  logic             w_one;
  logic             w_step;
  logic             w_term;

  assign w_ld_nz = (ld_val != '0);
  assign w_one   = (r_cnt == CNT_W'(1));
  // A load always wins over a step in the same cycle.
  assign w_step  = (r_state == RUN) && dec_en && !ld_cnt;
  assign w_term  = w_step && w_one;

  always_ff @(posedge i_clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ld_cnt) begin
        r_reload <= ld_val;
        r_cnt    <= ld_val;
        r_state  <= w_ld_nz ? RUN : IDLE;
      end else if (w_term) begin
        r_done <= 1'b1;
        if (AUTO_RELOAD) begin
          // Keep running with the stored count for the next division.
          r_cnt   <= r_reload;
          r_state <= RUN;
        end else begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      end else if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign counter = r_cnt;
  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign zero    = (r_cnt == '0);
  assign last    = busy && w_one;

endmodule

// File: tb/tb_param_iter_counter.sv
// Self-checking bench for param_iter_counter.
// Three configurations: 3-bit stop, 4-bit auto-reload, 8-bit stop.
module tb_param_iter_counter;

  logic i_clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       ld3, dec3, busy3, last3, zero3, done3;
  logic [2:0] val3, cnt3;
  logic       ld4, dec4, busy4, last4, zero4, done4;
  logic [3:0] val4, cnt4;
  logic       ld8, dec8, busy8, last8, zero8, done8;
  logic [7:0] val8, cnt8;

  param_iter_counter #(.CNT_W(3), .AUTO_RELOAD(1'b0)) u3 (
    .i_clk(i_clk), .clr_n(clr_n), .ld_cnt(ld3), .ld_val(val3),
    .dec_en(dec3), .counter(cnt3), .busy(busy3), .last(last3),
    .zero(zero3), .done(done3));

  param_iter_counter #(.CNT_W(4), .AUTO_RELOAD(1'b1)) u4 (
    .i_clk(i_clk), .clr_n(clr_n), .ld_cnt(ld4), .ld_val(val4),
    .dec_en(dec4), .counter(cnt4), .busy(busy4), .last(last4),
    .zero(zero4), .done(done4));

  param_iter_counter #(.CNT_W(8), .AUTO_RELOAD(1'b0)) u8 (
    .i_clk(i_clk), .clr_n(clr_n), .ld_cnt(ld8), .ld_val(val8),
    .dec_en(dec8), .counter(cnt8), .busy(busy8), .last(last8),
    .zero(zero8), .done(done8));

  int nchk = 0;
  int nerr = 0;

  // Reference: remaining iterations per instance (0 = u3, 1 = u4, 2 = u8).
  int m_cnt [3];
  int m_rel [3];
  bit m_run [3];
  bit m_done[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit ld, input int val,
                            input bit dec, input bit ar);
    m_done[k] = 0;
    if (ld) begin
      m_rel[k] = val;
      m_cnt[k] = val;
      m_run[k] = (val != 0);
    end else if (m_run[k] && dec) begin
      m_cnt[k] = m_cnt[k] - 1;
      if (m_cnt[k] == 0) begin
        m_done[k] = 1;
        if (ar) m_cnt[k] = m_rel[k];
        else    m_run[k] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld3 = 0; dec3 = 0; val3 = '0;
    ld4 = 0; dec4 = 0; val4 = '0;
    ld8 = 0; dec8 = 0; val8 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge i_clk);
    clr_n = 0;
    @(negedge i_clk);
    clr_n = 1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    clr_n = 0;
    cyc();
    cyc();
    nchk++;
    if ({cnt3, busy3, done3, zero3, last3} !== {3'd0, 4'b0010}) begin
      nerr++;
      $display("FAIL reset_u3 got cnt=%0d b=%b d=%b z=%b l=%b want 0 0 0 1 0",
               cnt3, busy3, done3, zero3, last3);
    end
    nchk++;
    if ({cnt4, busy4, done4, zero4, last4} !== {4'd0, 4'b0010}) begin
      nerr++;
      $display("FAIL reset_u4 got cnt=%0d b=%b d=%b z=%b l=%b want 0 0 0 1 0",
               cnt4, busy4, done4, zero4, last4);
    end
    nchk++;
    if ({cnt8, busy8, done8, zero8, last8} !== {8'd0, 4'b0010}) begin
      nerr++;
      $display("FAIL reset_u8 got cnt=%0d b=%b d=%b z=%b l=%b want 0 0 0 1 0",
               cnt8, busy8, done8, zero8, last8);
    end
    clr_n = 1;
    cyc();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ld3 = 1; val3 = 3'd4;
    cyc();
    ld3 = 0; dec3 = 1;
    cyc();
    cyc();
    dec3 = 0;
    nchk++;
    if (cnt3 !== 3'd2 || busy3 !== 1'b1) begin
      nerr++;
      $display("FAIL midrun_pre got cnt=%0d busy=%b want 2 1", cnt3, busy3);
    end
    #2;
    clr_n = 0;
    #1;
    nchk++;
    if ({cnt3, busy3, done3, zero3, last3} !== {3'd0, 4'b0010}) begin
      nerr++;
      $display("FAIL midrun_async got cnt=%0d b=%b d=%b z=%b l=%b want 0 0 0 1 0",
               cnt3, busy3, done3, zero3, last3);
    end
    @(negedge i_clk);
    clr_n = 1;
    cyc();
  endtask

  task automatic test_basic();
    int exp_seq[4] = '{3, 2, 1, 0};
    int ndone = 0;
    do_reset();
    ld3 = 1; val3 = 3'd4;
    cyc();
    ld3 = 0;
    nchk++;
    if (cnt3 !== 3'd4 || busy3 !== 1 || last3 !== 0 || done3 !== 0) begin
      nerr++;
      $display("FAIL basic_load got cnt=%0d b=%b l=%b d=%b want 4 1 0 0",
               cnt3, busy3, last3, done3);
    end
    dec3 = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (done3) ndone++;
      nchk++;
      if (int'(cnt3) !== exp_seq[i] || last3 !== (exp_seq[i] == 1) ||
          done3 !== (exp_seq[i] == 0) || busy3 !== (exp_seq[i] != 0)) begin
        nerr++;
        $display("FAIL basic_step%0d got cnt=%0d l=%b d=%b b=%b want cnt=%0d",
                 i, cnt3, last3, done3, busy3, exp_seq[i]);
      end
    end
    cyc();
    cyc();
    if (done3) ndone++;
    dec3 = 0;
    nchk++;
    if (cnt3 !== 3'd0 || zero3 !== 1 || ndone != 1) begin
      nerr++;
      $display("FAIL basic_hold got cnt=%0d z=%b dones=%0d want 0 1 1",
               cnt3, zero3, ndone);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ld3 = 1; val3 = 3'd2;
    cyc();
    ld3 = 0; dec3 = 1;
    cyc();
    nchk++;
    if (cnt3 !== 3'd1 || last3 !== 1) begin
      nerr++;
      $display("FAIL simul_pre got cnt=%0d last=%b want 1 1", cnt3, last3);
    end
    ld3 = 1; val3 = 3'd5; dec3 = 1;
    cyc();
    ld3 = 0; dec3 = 0;
    nchk++;
    if (cnt3 !== 3'd5 || busy3 !== 1 || done3 !== 0) begin
      nerr++;
      $display("FAIL simul_ld_dec got cnt=%0d b=%b d=%b want 5 1 0",
               cnt3, busy3, done3);
    end
  endtask

  task automatic test_zero_load();
    do_reset();
    ld3 = 1; val3 = 3'd0;
    cyc();
    ld3 = 0; dec3 = 1;
    nchk++;
    if (cnt3 !== 0 || busy3 !== 0 || done3 !== 0 || zero3 !== 1) begin
      nerr++;
      $display("FAIL zero_load got cnt=%0d b=%b d=%b z=%b want 0 0 0 1",
               cnt3, busy3, done3, zero3);
    end
    cyc();
    nchk++;
    if (cnt3 !== 0 || busy3 !== 0 || done3 !== 0) begin
      nerr++;
      $display("FAIL zero_dec got cnt=%0d b=%b d=%b want 0 0 0",
               cnt3, busy3, done3);
    end
    dec3 = 0; ld3 = 1; val3 = 3'd3;
    cyc();
    ld3 = 1; val3 = 3'd0;
    cyc();
    ld3 = 0;
    nchk++;
    if (cnt3 !== 0 || busy3 !== 0 || done3 !== 0) begin
      nerr++;
      $display("FAIL zero_reload_run got cnt=%0d b=%b d=%b want 0 0 0",
               cnt3, busy3, done3);
    end
  endtask

  task automatic test_auto_reload();
    int exp_seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int ndone = 0;
    int bad = 0;
    do_reset();
    ld4 = 1; val4 = 4'd3;
    cyc();
    ld4 = 0; dec4 = 1;
    nchk++;
    if (cnt4 !== 4'd3 || busy4 !== 1) begin
      nerr++;
      $display("FAIL ar_load got cnt=%0d b=%b want 3 1", cnt4, busy4);
    end
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (done4) ndone++;
      nchk++;
      if (int'(cnt4) !== exp_seq[i] || busy4 !== 1 ||
          done4 !== (exp_seq[i] == 3)) begin
        nerr++;
        $display("FAIL ar_step%0d got cnt=%0d b=%b d=%b want cnt=%0d",
                 i, cnt4, busy4, done4, exp_seq[i]);
      end
    end
    dec4 = 0;
    nchk++;
    if (ndone != 3) begin
      nerr++;
      $display("FAIL ar_done_count got %0d want 3", ndone);
    end
    bad = 0;
  endtask

  task automatic test_max_width();
    int ndone = 0;
    int gap;
    do_reset();
    ld8 = 1; val8 = 8'd255;
    cyc();
    ld8 = 0;
    nchk++;
    if (cnt8 !== 8'd255 || busy8 !== 1) begin
      nerr++;
      $display("FAIL max_load got cnt=%0d b=%b want 255 1", cnt8, busy8);
    end
    for (int i = 0; i < 255; i++) begin
      gap = $urandom_range(0, 2);
      dec8 = 0;
      for (int g = 0; g < gap; g++) begin
        cyc();
        if (done8) ndone++;
      end
      dec8 = 1;
      cyc();
      if (done8) ndone++;
    end
    dec8 = 0;
    nchk++;
    if (cnt8 !== 8'd0 || busy8 !== 0 || ndone != 1) begin
      nerr++;
      $display("FAIL max_run got cnt=%0d b=%b dones=%0d want 0 0 1",
               cnt8, busy8, ndone);
    end
    dec8 = 1;
    cyc();
    cyc();
    dec8 = 0;
    nchk++;
    if (cnt8 !== 8'd0 || done8 !== 0) begin
      nerr++;
      $display("FAIL max_underflow got cnt=%0d d=%b want 0 0", cnt8, done8);
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      ld3 = ($urandom_range(0, 7) == 0);
      val3 = 3'($urandom_range(0, 7));
      dec3 = ($urandom_range(0, 3) != 0);
      ld4 = ($urandom_range(0, 9) == 0);
      val4 = 4'($urandom_range(0, 5));
      dec4 = ($urandom_range(0, 3) != 0);
      ld8 = ($urandom_range(0, 15) == 0);
      val8 = 8'($urandom_range(0, 20));
      dec8 = ($urandom_range(0, 3) != 0);
      model_step(0, ld3, int'(val3), dec3, 0);
      model_step(1, ld4, int'(val4), dec4, 1);
      model_step(2, ld8, int'(val8), dec8, 0);
      cyc();
      nchk++;
      if (int'(cnt3) !== m_cnt[0] || busy3 !== m_run[0] ||
          done3 !== m_done[0] || zero3 !== (m_cnt[0] == 0) ||
          last3 !== (m_run[0] && m_cnt[0] == 1)) begin
        nerr++;
        $display("FAIL rand_u3 n=%0d got cnt=%0d b=%b d=%b want cnt=%0d b=%b d=%b",
                 n, cnt3, busy3, done3, m_cnt[0], m_run[0], m_done[0]);
      end
      nchk++;
      if (int'(cnt4) !== m_cnt[1] || busy4 !== m_run[1] ||
          done4 !== m_done[1] || zero4 !== (m_cnt[1] == 0) ||
          last4 !== (m_run[1] && m_cnt[1] == 1)) begin
        nerr++;
        $display("FAIL rand_u4 n=%0d got cnt=%0d b=%b d=%b want cnt=%0d b=%b d=%b",
                 n, cnt4, busy4, done4, m_cnt[1], m_run[1], m_done[1]);
      end
      nchk++;
      if (int'(cnt8) !== m_cnt[2] || busy8 !== m_run[2] ||
          done8 !== m_done[2] || zero8 !== (m_cnt[2] == 0) ||
          last8 !== (m_run[2] && m_cnt[2] == 1)) begin
        nerr++;
        $display("FAIL rand_u8 n=%0d got cnt=%0d b=%b d=%b want cnt=%0d b=%b d=%b",
                 n, cnt8, busy8, done8, m_cnt[2], m_run[2], m_done[2]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_simultaneous();
    test_zero_load();
    test_auto_reload();
    test_max_width();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
